// File: rtl/clk_rst_sequencer.sv
// rtl/clk_rst_sequencer.sv - PLL reset, lock qualification and staged domain reset release
module clk_rst_sequencer #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int STAGE_GAP_CYC    = 64,
  parameter int NUM_DOMAINS      = 3,
  parameter int MAX_RETRY        = 3
) (
  input  logic                             clk,
  input  logic                             nRST,
  input  logic                             locked_in,
  input  logic                             soft_rst_req,
  input  logic                             clear_fault,
  output logic                             pll_reset,
  output logic [NUM_DOMAINS-1:0]           domain_rst_n,
  output logic                             sys_ready,
  output logic                             fault,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic [7:0]                       lock_loss_cnt,
  output logic [2:0]                       state
);

  localparam int MAX_A   = (LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ? LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC;
  localparam int MAX_B   = (RST_PULSE_CYC > STAGE_GAP_CYC) ? RST_PULSE_CYC : STAGE_GAP_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  // Terminal counts: the counter runs 0..N-1, so each phase lasts exactly N cycles
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(STAGE_GAP_CYC - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  logic                   lock_meta_q;
  logic                   locked_s_q;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   pll_reset_q, pll_reset_d;
  logic [NUM_DOMAINS-1:0] domain_rst_n_q, domain_rst_n_d;
  logic                   sys_ready_q, sys_ready_d;
  logic                   fault_q, fault_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [7:0]             lock_loss_q, lock_loss_d;
  logic                   lock_lost;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      lock_meta_q <= 1'b0;
      locked_s_q  <= 1'b0;
    end else begin
      lock_meta_q <= locked_in;
      locked_s_q  <= lock_meta_q;
    end
  end

  // Next-state, shared counter and output computation; outputs follow the next state
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CNT_W'(1);
    idx_d          = idx_q;
    domain_rst_n_d = domain_rst_n_q;
    retry_d        = retry_q;
    lock_loss_d    = lock_loss_q;
    lock_lost      = !locked_s_q && ((state_q == ST_RELEASE) || (state_q == ST_RUN));

    if (state_q == ST_FAULT) begin
      // Parked with the PLL held in reset until software intervenes
      cnt_d          = '0;
      domain_rst_n_d = '0;
      if (clear_fault || soft_rst_req) begin
        state_d = ST_PLL_RST;
        retry_d = '0;
      end
    end else if (soft_rst_req) begin
      // Software re-sequence wins over everything, including a coincident lock loss
      state_d        = ST_PLL_RST;
      cnt_d          = '0;
      retry_d        = '0;
      domain_rst_n_d = '0;
    end else if (lock_lost) begin
      state_d        = ST_PLL_RST;
      cnt_d          = '0;
      domain_rst_n_d = '0;
      if (lock_loss_q != 8'hFF) begin
        lock_loss_d = lock_loss_q + 8'd1;
      end
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_PLL_RST;
            end
          end
        end
        ST_STABLE: begin
          // Any drop restarts qualification; this is not a timeout, so retries stay as-is
          if (!locked_s_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d                 = '0;
            domain_rst_n_d[idx_q] = 1'b1;
            idx_d                 = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              retry_d = '0;
            end
          end
        end
        ST_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d        = ST_PLL_RST;
          cnt_d          = '0;
          domain_rst_n_d = '0;
        end
      endcase
    end

    pll_reset_d = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    sys_ready_d = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q        <= ST_PLL_RST;
      cnt_q          <= '0;
      idx_q          <= '0;
      pll_reset_q    <= 1'b1;
      domain_rst_n_q <= '0;
      sys_ready_q    <= 1'b0;
      fault_q        <= 1'b0;
      retry_q        <= '0;
      lock_loss_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      pll_reset_q    <= pll_reset_d;
      domain_rst_n_q <= domain_rst_n_d;
      sys_ready_q    <= sys_ready_d;
      fault_q        <= fault_d;
      retry_q        <= retry_d;
      lock_loss_q    <= lock_loss_d;
    end
  end

  assign pll_reset     = pll_reset_q;
  assign domain_rst_n  = domain_rst_n_q;
  assign sys_ready     = sys_ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = lock_loss_q;
  assign state         = state_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb/tb_clk_rst_sequencer.sv - randomized bench for clk_rst_sequencer against a phase/elapsed-time model
module tb_clk_rst_sequencer;

  localparam int RP  = 4;
  localparam int TO  = 32;
  localparam int LS  = 8;
  localparam int GAP = 4;
  localparam int ND  = 3;
  localparam int MR  = 2;
  localparam int RW  = $clog2(MR + 1);

  localparam int P_PLL   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_REL   = 3;
  localparam int P_RUN   = 4;
  localparam int P_FAULT = 5;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          locked_in = 1'b0;
  logic          soft_rst_req = 1'b0;
  logic          clear_fault = 1'b0;
  logic          pll_reset;
  logic [ND-1:0] domain_rst_n;
  logic          sys_ready;
  logic          fault;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    lock_loss_cnt;
  logic [2:0]    state;

  clk_rst_sequencer #(
    .RST_PULSE_CYC   (RP),
    .LOCK_TIMEOUT_CYC(TO),
    .LOCK_STABLE_CYC (LS),
    .STAGE_GAP_CYC   (GAP),
    .NUM_DOMAINS     (ND),
    .MAX_RETRY       (MR)
  ) dut (
    .clk          (clk),
    .nRST         (nRST),
    .locked_in    (locked_in),
    .soft_rst_req (soft_rst_req),
    .clear_fault  (clear_fault),
    .pll_reset    (pll_reset),
    .domain_rst_n (domain_rst_n),
    .sys_ready    (sys_ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tk       = 0;

  // Reference model: current phase plus cycles elapsed in it
  int m_ph, m_t, m_retry, m_llc;
  bit m_meta, m_ls;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_ph = P_PLL; m_t = 0; m_retry = 0; m_llc = 0; m_meta = 0; m_ls = 0;
  endtask

  task automatic m_enter(input int p);
    m_ph = p;
    m_t  = 0;
  endtask

  task automatic model_step();
    bit ls;
    if (!nRST) begin
      model_reset();
      return;
    end
    ls = m_ls;
    m_ls = m_meta;
    m_meta = locked_in;
    if (m_ph == P_FAULT) begin
      if (clear_fault || soft_rst_req) begin m_retry = 0; m_enter(P_PLL); end
    end else if (soft_rst_req) begin
      m_retry = 0; m_enter(P_PLL);
    end else if ((m_ph == P_REL || m_ph == P_RUN) && !ls) begin
      if (m_llc < 255) m_llc++;
      m_enter(P_PLL);
    end else begin
      case (m_ph)
        P_PLL: begin m_t++; if (m_t == RP) m_enter(P_WAIT); end
        P_WAIT: begin
          if (ls) m_enter(P_STAB);
          else begin
            m_t++;
            if (m_t == TO) begin
              if (m_retry == MR) m_enter(P_FAULT);
              else begin m_retry++; m_enter(P_PLL); end
            end
          end
        end
        P_STAB: begin
          if (!ls) m_enter(P_WAIT);
          else begin m_t++; if (m_t == LS) m_enter(P_REL); end
        end
        P_REL: begin
          m_t++;
          if (m_t == ND * GAP) begin m_retry = 0; m_enter(P_RUN); end
        end
        default: ;
      endcase
    end
  endtask

  function automatic int exp_domains();
    if (m_ph == P_RUN) return (1 << ND) - 1;
    if (m_ph == P_REL) return (1 << (m_t / GAP)) - 1;
    return 0;
  endfunction

  task automatic check_outputs();
    check_eq("state", int'(state), m_ph);
    check_eq("pll_reset", int'(pll_reset), int'(m_ph == P_PLL || m_ph == P_FAULT));
    check_eq("domain_rst_n", int'(domain_rst_n), exp_domains());
    check_eq("sys_ready", int'(sys_ready), int'(m_ph == P_RUN));
    check_eq("fault", int'(fault), int'(m_ph == P_FAULT));
    check_eq("retry_cnt", int'(retry_cnt), m_retry);
    check_eq("lock_loss_cnt", int'(lock_loss_cnt), m_llc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    tk++;
  endtask

  task automatic wait_model(input string tag, input int ph, input int tmin, input int budget);
    int n = 0;
    while (!(m_ph == ph && m_t >= tmin) && n < budget) begin
      tick();
      n++;
    end
    check_eq({"bound_", tag}, int'(m_ph == ph && m_t >= tmin), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, int'(state), 0);
    check_eq({tag, "_pll"}, int'(pll_reset), 1);
    check_eq({tag, "_dom"}, int'(domain_rst_n), 0);
    check_eq({tag, "_ready"}, int'(sys_ready), 0);
    check_eq({tag, "_fault"}, int'(fault), 0);
    check_eq({tag, "_retry"}, int'(retry_cnt), 0);
    check_eq({tag, "_llc"}, int'(lock_loss_cnt), 0);
  endtask

  initial begin
    int pll_hi, t0, t_stab, t_rel, t_d0, t_d1, t_d2, n, llc_before, hold, r;

    // Reset state
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("reset");
    tick();
    nRST = 1'b1;

    // Normal bring-up: pulse width, lock latency, staged release
    pll_hi = int'(pll_reset);
    for (int i = 0; i < 10; i++) begin
      tick();
      pll_hi += int'(pll_reset);
    end
    check_eq("pll_pulse_len", pll_hi, RP);
    locked_in = 1'b1;
    t0 = tk; t_stab = -1; t_rel = -1; t_d0 = -1; t_d1 = -1; t_d2 = -1; n = 0;
    while (!sys_ready && n < 100) begin
      tick();
      n++;
      if (state == 3'd2 && t_stab < 0) t_stab = tk - t0;
      if (state == 3'd3 && t_rel < 0) t_rel = tk;
      if (domain_rst_n == 3'b001 && t_d0 < 0) t_d0 = tk - t_rel;
      if (domain_rst_n == 3'b011 && t_d1 < 0) t_d1 = tk - t_rel;
      if (domain_rst_n == 3'b111 && t_d2 < 0) t_d2 = tk - t_rel;
    end
    check_eq("lock_latency", t_stab, 3);
    check_eq("release_d0", t_d0, GAP);
    check_eq("release_d1", t_d1, 2 * GAP);
    check_eq("release_d2", t_d2, 3 * GAP);
    check_eq("ready_domains", int'(domain_rst_n), 7);
    check_eq("ready_retry", int'(retry_cnt), 0);
    for (int i = 0; i < 5; i++) tick();

    // Lock loss in RUN: three edges to domain reset
    locked_in = 1'b0;
    n = 0;
    while (domain_rst_n != '0 && n < 10) begin
      tick();
      n++;
    end
    check_eq("loss_latency", n, 3);
    check_eq("loss_ready", int'(sys_ready), 0);
    check_eq("loss_llc", int'(lock_loss_cnt), 1);
    check_eq("loss_state", int'(state), 0);

    // Lock never returns: retries exhaust into FAULT
    wait_model("fault", P_FAULT, 0, 300);
    check_eq("fault_flag", int'(fault), 1);
    check_eq("fault_pll", int'(pll_reset), 1);
    check_eq("fault_retry", int'(retry_cnt), MR);
    tick();
    locked_in = 1'b1;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check_eq("clear_state", int'(state), 0);
    check_eq("clear_fault", int'(fault), 0);

    // Unstable lock during STABLE
    wait_model("stable_mid", P_STAB, 4, 100);
    locked_in = 1'b0;
    tick();
    tick();
    locked_in = 1'b1;
    wait_model("run3", P_RUN, 0, 200);

    // Soft request coincident with lock loss mid-RELEASE
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    wait_model("rel5", P_REL, GAP, 100);
    locked_in = 1'b0;
    tick();
    tick();
    llc_before = m_llc;
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check_eq("soft_state", int'(state), 0);
    check_eq("soft_dom", int'(domain_rst_n), 0);
    check_eq("soft_llc", int'(lock_loss_cnt), llc_before);
    locked_in = 1'b1;

    // 256 lock losses saturate the counter
    for (int k = 0; k < 256; k++) begin
      wait_model("rel6", P_REL, 0, 100);
      locked_in = 1'b0;
      tick();
      locked_in = 1'b1;
      tick();
      tick();
    end
    check_eq("llc_saturated", int'(lock_loss_cnt), 255);

    // Asynchronous reset mid-RELEASE
    wait_model("rel_async", P_REL, 5, 100);
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    check_reset_values("async");
    tick();
    tick();
    nRST = 1'b1;

    // Randomized lock behaviour with occasional software requests
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        r = int'($urandom_range(0, 15));
        if (r == 0) begin
          locked_in = 1'b0;
          hold = int'($urandom_range(90, 140));
        end else if (r < 5) begin
          locked_in = 1'b0;
          hold = int'($urandom_range(1, 6));
        end else begin
          locked_in = 1'b1;
          hold = int'($urandom_range(10, 80));
        end
      end
      hold--;
      soft_rst_req = ($urandom_range(0, 299) == 0);
      clear_fault  = ($urandom_range(0, 7) == 0);
      tick();
    end
    soft_rst_req = 1'b0;
    clear_fault  = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_rst_sequencer.md
# clk_rst_sequencer

Power-up and lock-recovery controller for the clock generation block. It drives the PLL reset, watches the PLL lock, and requires lock to be stable for a programmable time. It then releases per-domain reset enables one at a time, and re-sequences on lock loss or software request. Its `domain_rst_n` outputs gate the existing per-domain reset synchronizers, so no downstream domain leaves reset before its clock is clean.

## Interface
- `RST_PULSE_CYC`, 16: PLL reset pulse width in cycles (≥2).
- `LOCK_TIMEOUT_CYC`, 65536: cycles to wait for lock before retrying.
- `LOCK_STABLE_CYC`, 1024: cycles lock must hold continuously before release.
- `STAGE_GAP_CYC`, 64: cycles between successive domain releases.
- `NUM_DOMAINS`, 3: number of staged domain resets (1–8).
- `MAX_RETRY`, 3: lock timeouts tolerated before FAULT.

Ports:
- `clk` in 1: free-running reference clock, not PLL-derived.
- `nRST` in 1: reset, asynchronous and active-low.
- `locked_in` in 1: PLL lock, asynchronous; double-flop synchronized internally into `locked_s`.
- `soft_rst_req` in 1: single-cycle request to re-sequence from PLL reset.
- `clear_fault` in 1: single-cycle request to leave FAULT.
- `pll_reset` out 1: active-high PLL reset.
- `domain_rst_n` out NUM_DOMAINS: per-domain release, active-low reset; bit 0 is released first.
- `sys_ready` out 1: all domains released and in RUN.
- `fault` out 1: retry limit exhausted.
- `retry_cnt` out $clog2(MAX_RETRY+1): timeouts in the current bring-up.
- `lock_loss_cnt` out 8: lock losses in RELEASE/RUN, saturating at 255.
- `state` out 3: encoded current state.

## Operation
- **Outputs:** all registered. A single shared counter `cnt` is cleared on every state transition. Its width is enough for max(LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC, RST_PULSE_CYC, STAGE_GAP_CYC).
- **PLL_RST (0):** `pll_reset`=1, all `domain_rst_n`=0.
  - At `cnt==RST_PULSE_CYC-1`, go to WAIT_LOCK.
- **WAIT_LOCK (1):** `pll_reset`=0.
  - If `locked_s`=1, go to STABLE.
  - Else if `cnt==LOCK_TIMEOUT_CYC-1`:
    - if `retry_cnt==MAX_RETRY`, go to FAULT;
    - otherwise increment `retry_cnt` and go to PLL_RST.
- **STABLE (2):**
  - If `locked_s`=0, go to WAIT_LOCK; `retry_cnt` is unchanged.
  - Else at `cnt==LOCK_STABLE_CYC-1`, go to RELEASE with stage index `idx`=0.
- **RELEASE (3):**
  - At `cnt==STAGE_GAP_CYC-1`: set `domain_rst_n[idx]`=1, increment `idx`, clear `cnt`.
  - When the bit just set is bit NUM_DOMAINS-1, go to RUN.
- **RUN (4):** `sys_ready`=1 and `retry_cnt` cleared, both on the same edge the state enters RUN.
- **Lock loss:** `locked_s`=0 while in RELEASE or RUN causes, on the next edge:
  - all `domain_rst_n`=0 and `sys_ready`=0;
  - `lock_loss_cnt` increments (saturating);
  - go to PLL_RST.
- **FAULT (5):** `pll_reset`=1, `fault`=1, all `domain_rst_n`=0.
  - `clear_fault` or `soft_rst_req` leads to PLL_RST with `retry_cnt`=0 and `fault`=0.
- **`soft_rst_req` in any non-FAULT state:** go to PLL_RST, all `domain_rst_n`=0, `sys_ready`=0, `retry_cnt`=0.
  - In PLL_RST it restarts the pulse (`cnt` cleared).
- **Priority:** `soft_rst_req` > lock loss > timeout/progress.
- **Unused encodings:** 6 and 7 go to PLL_RST.

## Timing
- **Reset values:** `state`=PLL_RST, `cnt`=0, `pll_reset`=1, `domain_rst_n`=0, `sys_ready`=0, `fault`=0, `retry_cnt`=0, `lock_loss_cnt`=0, synchronizer flops=0.
- **PLL reset pulse:** `pll_reset` is high for exactly RST_PULSE_CYC cycles after PLL_RST entry or `nRST` release.
- **Lock latency:** `locked_in` rising reaches `locked_s` after 2 edges; STABLE is entered on the 3rd edge.
- **Domain release:** `domain_rst_n[i]` rises exactly (i+1)·STAGE_GAP_CYC cycles after RELEASE entry. `sys_ready` rises on the same edge as the last bit.
- **Release time:** from lock-stable entry to `sys_ready` is LOCK_STABLE_CYC + NUM_DOMAINS·STAGE_GAP_CYC cycles.
- **Lock-loss response:** from the `locked_in` fall to `domain_rst_n`=0 is 3 edges (2 synchronizer + 1 registered).
- **Glitches:** lock glitches shorter than one cycle may be missed; no filtering is required beyond the STABLE window.
- **Mid-operation reset:** `nRST` asserted asynchronously forces all reset values immediately, with no completion of the current stage.

## Test plan
Parameters for all scenarios: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, STAGE_GAP_CYC=4, NUM_DOMAINS=3, MAX_RETRY=2.

1. **Normal bring-up.** Release `nRST`, raise `locked_in` 10 cycles later.
   - `pll_reset` high for 4 cycles.
   - `domain_rst_n` goes 001, 011, 111 at 4, 8, 12 cycles after RELEASE entry.
   - `sys_ready`=1 with 111; `retry_cnt`=0.
2. **Timeout to FAULT.** Keep `locked_in`=0.
   - Three 32-cycle WAIT_LOCK windows, `retry_cnt` 0 → 1 → 2, then `state`=5, `fault`=1, `pll_reset`=1.
   - `clear_fault` gives `state`=0 and `fault`=0.
3. **Unstable lock.** Drop `locked_in` for 2 cycles in the middle of STABLE.
   - Return to WAIT_LOCK, `retry_cnt` unchanged, no domain released.
   - After lock returns, STABLE restarts the full 8 cycles.
4. **Lock loss in RUN.** Drop `locked_in` while in RUN.
   - 3 edges later `domain_rst_n`=000 and `sys_ready`=0.
   - `lock_loss_cnt` 0 → 1; `state`=0; full re-sequence follows.
5. **Soft request vs. lock loss.** Assert `soft_rst_req` mid-RELEASE with `domain_rst_n`=001, in the same cycle as `locked_s` falls.
   - Next edge: `state`=0, `domain_rst_n`=000.
   - `lock_loss_cnt` unchanged (soft request has priority).
6. **Saturation and async reset.** Force 256 lock losses, then assert `nRST` in the middle of RELEASE.
   - `lock_loss_cnt` reads 255 after the 256th loss.
   - On `nRST`, all outputs take reset values immediately.
